// File: rtl/pe_pkg.sv
// Shared types, default widths and the saturating clamp used by the
// fixed-point MAC processing element.
package pe_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  // Intermediate width for clamping; must cover 2*DATA_WIDTH+1 and ACC_WIDTH+1.
  localparam int CALC_W = 64;

  function automatic logic signed [CALC_W-1:0] sat_clamp(
    input logic signed [CALC_W-1:0] v,
    input int                       w
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_fxp_mul_rnd.sv
// Combinational signed fixed-point multiply with round-half-up and shift;
// also reports whether the result overflows a DATA_WIDTH word.
module pe_fxp_mul_rnd
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [2*DATA_WIDTH:0] prod,
  output logic signed [DATA_WIDTH-1:0] prod_w,
  output logic                         sat
);

  localparam int PW = 2 * DATA_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC_BITS - 1);

  logic signed [PW-1:0]     full;
  logic signed [PW-1:0]     rounded;
  logic signed [CALC_W-1:0] wide;
  logic signed [CALC_W-1:0] clamped;

  // One guard bit above the 2*DATA_WIDTH product keeps the rounding add exact.
  assign full    = PW'(a) * PW'(b);
  assign rounded = full + RND;
  assign prod    = rounded >>> FRAC_BITS;
  assign wide    = CALC_W'(prod);
  assign clamped = sat_clamp(wide, DATA_WIDTH);
  assign prod_w  = clamped[DATA_WIDTH-1:0];
  assign sat     = (clamped != wide);

endmodule

// File: rtl/pe_mac_db.sv
// Systolic-array MAC cell: double-buffered weights with switch bypass,
// weight-stationary and output-stationary (accumulate/drain) modes.
module pe_mac_db
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_enabled,
  input  logic                  pe_mode_in,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  input  logic                  pe_psum_valid_in,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  input  logic                  pe_accept_w_in,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  input  logic                  pe_valid_in,
  input  logic                  pe_switch_in,
  input  logic                  pe_drain_in,
  input  logic                  pe_sat_clr,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  output logic                  pe_psum_valid_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  output logic                  pe_accept_w_out,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  output logic                  pe_valid_out,
  output logic                  pe_switch_out,
  output logic                  pe_drain_out,
  output logic                  pe_sat_out
);

  pe_mode_e mode;

  logic signed [DATA_WIDTH-1:0] w_active;
  logic signed [DATA_WIDTH-1:0] w_inactive;
  logic                         w_full;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         sat;

  logic                         promote;
  logic signed [DATA_WIDTH-1:0] w_eff;
  logic signed [2*DATA_WIDTH:0] prod;
  logic signed [DATA_WIDTH-1:0] prod_w;
  logic                         mul_sat;

  logic signed [CALC_W-1:0] ws_sum;
  logic signed [CALC_W-1:0] ws_clamped;
  logic signed [CALC_W-1:0] acc_sum;
  logic signed [CALC_W-1:0] acc_clamped;
  logic signed [CALC_W-1:0] acc_wide;
  logic signed [CALC_W-1:0] drain_clamped;
  logic signed [CALC_W-1:0] prod_wide;
  logic signed [CALC_W-1:0] prod_acc;

  logic [DATA_WIDTH-1:0] psum_d;
  logic                  psum_valid_d;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic                  sat_evt;

  assign mode    = pe_mode_e'(pe_mode_in);
  assign promote = pe_switch_in & w_full;
  // A MAC in the switch cycle already sees the promoted weight.
  assign w_eff   = promote ? w_inactive : w_active;

  pe_fxp_mul_rnd #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .a     (pe_input_in),
    .b     (w_eff),
    .prod  (prod),
    .prod_w(prod_w),
    .sat   (mul_sat)
  );

  assign ws_sum        = CALC_W'(prod_w) + CALC_W'($signed(pe_psum_in));
  assign ws_clamped    = sat_clamp(ws_sum, DATA_WIDTH);
  assign prod_wide     = CALC_W'(prod);
  assign acc_wide      = CALC_W'(acc);
  assign acc_sum       = acc_wide + prod_wide;
  assign acc_clamped   = sat_clamp(acc_sum, ACC_WIDTH);
  assign drain_clamped = sat_clamp(acc_wide, DATA_WIDTH);
  assign prod_acc      = sat_clamp(prod_wide, ACC_WIDTH);

  always_comb begin
    psum_d       = '0;
    psum_valid_d = 1'b0;
    acc_d        = acc;
    sat_evt      = 1'b0;
    if (mode == PE_WS) begin
      acc_d = '0;
      if (pe_valid_in) begin
        psum_d       = ws_clamped[DATA_WIDTH-1:0];
        psum_valid_d = 1'b1;
        sat_evt      = mul_sat | (ws_clamped != ws_sum);
      end
    end else begin
      if (pe_valid_in) begin
        acc_d   = acc_clamped[ACC_WIDTH-1:0];
        sat_evt = (acc_clamped != acc_sum);
      end
      if (pe_drain_in) begin
        // Drain restarts the tile; a colliding north psum is dropped and flagged.
        psum_d       = drain_clamped[DATA_WIDTH-1:0];
        psum_valid_d = 1'b1;
        acc_d        = pe_valid_in ? prod_acc[ACC_WIDTH-1:0] : '0;
        sat_evt      = (drain_clamped != acc_wide) | pe_psum_valid_in
                     | (pe_valid_in & (prod_acc != prod_wide));
      end else begin
        psum_d       = pe_psum_in;
        psum_valid_d = pe_psum_valid_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_active          <= '0;
      w_inactive        <= '0;
      w_full            <= 1'b0;
      acc               <= '0;
      sat               <= 1'b0;
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
    end else if (!pe_enabled) begin
      pe_psum_out       <= '0;
      pe_psum_valid_out <= 1'b0;
      pe_weight_out     <= '0;
      pe_accept_w_out   <= 1'b0;
      pe_input_out      <= '0;
      pe_valid_out      <= 1'b0;
      pe_switch_out     <= 1'b0;
      pe_drain_out      <= 1'b0;
    end else begin
      if (promote) w_active <= w_inactive;
      if (pe_accept_w_in) w_inactive <= pe_weight_in;
      w_full            <= pe_accept_w_in | (w_full & ~promote);
      acc               <= acc_d;
      sat               <= sat_evt | (sat & ~pe_sat_clr);
      pe_psum_out       <= psum_d;
      pe_psum_valid_out <= psum_valid_d;
      pe_weight_out     <= pe_accept_w_in ? pe_weight_in : '0;
      pe_accept_w_out   <= pe_accept_w_in;
      if (pe_valid_in) pe_input_out <= pe_input_in;
      pe_valid_out      <= pe_valid_in;
      pe_switch_out     <= pe_switch_in;
      pe_drain_out      <= pe_drain_in;
    end
  end

  assign pe_sat_out = sat;

endmodule

// File: tb/tb_pe_mac_db.sv
// Directed bench for pe_mac_db (Q8.8, 16-bit): per-cycle vector table plus
// hand sequences for forwards, enable and asynchronous reset.
module tb_pe_mac_db;

  logic        clk = 1'b0;
  logic        rst;
  logic        pe_enabled;
  logic        pe_mode_in;
  logic [15:0] pe_psum_in;
  logic        pe_psum_valid_in;
  logic [15:0] pe_weight_in;
  logic        pe_accept_w_in;
  logic [15:0] pe_input_in;
  logic        pe_valid_in;
  logic        pe_switch_in;
  logic        pe_drain_in;
  logic        pe_sat_clr;
  logic [15:0] pe_psum_out;
  logic        pe_psum_valid_out;
  logic [15:0] pe_weight_out;
  logic        pe_accept_w_out;
  logic [15:0] pe_input_out;
  logic        pe_valid_out;
  logic        pe_switch_out;
  logic        pe_drain_out;
  logic        pe_sat_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        mode;
    logic [15:0] w;
    logic        aw;
    logic        sw;
    logic [15:0] inp;
    logic        v;
    logic [15:0] ps;
    logic        pv;
    logic        dr;
    logic        clr;
    logic [15:0] e_ps;
    logic        e_pv;
    logic        e_sat;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  pe_mac_db #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .pe_enabled       (pe_enabled),
    .pe_mode_in       (pe_mode_in),
    .pe_psum_in       (pe_psum_in),
    .pe_psum_valid_in (pe_psum_valid_in),
    .pe_weight_in     (pe_weight_in),
    .pe_accept_w_in   (pe_accept_w_in),
    .pe_input_in      (pe_input_in),
    .pe_valid_in      (pe_valid_in),
    .pe_switch_in     (pe_switch_in),
    .pe_drain_in      (pe_drain_in),
    .pe_sat_clr       (pe_sat_clr),
    .pe_psum_out      (pe_psum_out),
    .pe_psum_valid_out(pe_psum_valid_out),
    .pe_weight_out    (pe_weight_out),
    .pe_accept_w_out  (pe_accept_w_out),
    .pe_input_out     (pe_input_out),
    .pe_valid_out     (pe_valid_out),
    .pe_switch_out    (pe_switch_out),
    .pe_drain_out     (pe_drain_out),
    .pe_sat_out       (pe_sat_out)
  );

  function automatic void add(input logic en, input logic mode, input logic [15:0] w,
                              input logic aw, input logic sw, input logic [15:0] inp,
                              input logic v, input logic [15:0] ps, input logic pv,
                              input logic dr, input logic clr, input logic [15:0] e_ps,
                              input logic e_pv, input logic e_sat);
    vec_t t;
    t.en = en; t.mode = mode; t.w = w; t.aw = aw; t.sw = sw; t.inp = inp; t.v = v;
    t.ps = ps; t.pv = pv; t.dr = dr; t.clr = clr;
    t.e_ps = e_ps; t.e_pv = e_pv; t.e_sat = e_sat;
    vecs.push_back(t);
  endfunction

  // driver
  task automatic drive(input vec_t t);
    pe_enabled       = t.en;
    pe_mode_in       = t.mode;
    pe_weight_in     = t.w;
    pe_accept_w_in   = t.aw;
    pe_switch_in     = t.sw;
    pe_input_in      = t.inp;
    pe_valid_in      = t.v;
    pe_psum_in       = t.ps;
    pe_psum_valid_in = t.pv;
    pe_drain_in      = t.dr;
    pe_sat_clr       = t.clr;
  endtask

  task automatic idle_inputs();
    vec_t t;
    t = '{en: 1'b1, mode: 1'b0, w: 16'h0, aw: 1'b0, sw: 1'b0, inp: 16'h0, v: 1'b0,
          ps: 16'h0, pv: 1'b0, dr: 1'b0, clr: 1'b0, e_ps: 16'h0, e_pv: 1'b0, e_sat: 1'b0};
    drive(t);
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en mode w     aw sw inp    v  ps     pv dr clr  e_ps  e_pv e_sat
    add(1, 0, 16'h0200, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0180, 1, 16'h0100, 0, 0, 0, 16'h0400, 1, 0);
    add(1, 0, 16'h0100, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0300, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0300, 1, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0300, 1, 0);
    add(1, 0, 16'h0200, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0400, 1, 1, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0200, 1, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0400, 1, 0);
    add(1, 0, 16'h7F00, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h7F00, 1, 16'h0000, 0, 0, 0, 16'h7FFF, 1, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h8000, 1, 16'h0000, 0, 0, 0, 16'h8000, 1, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h8000, 1, 16'h0000, 0, 0, 1, 16'h8000, 1, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(1, 0, 16'h0001, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0080, 1, 16'h0010, 0, 0, 0, 16'h0011, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 16'hFF7F, 1, 16'h0000, 0, 0, 0, 16'hFFFF, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0080, 1, 16'h7FFF, 0, 0, 0, 16'h7FFF, 1, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(1, 0, 16'h0100, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0200, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0300, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0100, 1, 16'h0000, 0, 1, 0, 16'h0600, 1, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0100, 1, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 1, 0, 0, 16'h1234, 1, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0200, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 1, 1, 0, 16'h0200, 1, 1);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h7F00, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h7F00, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h7FFF, 1, 1);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 1, 0, 0, 16'h0000, 0, 0);
    add(0, 0, 16'h0700, 1, 1, 16'h0100, 1, 16'h0100, 0, 0, 0, 16'h0000, 0, 0);
    add(0, 0, 16'h0700, 1, 1, 16'h0100, 1, 16'h0100, 0, 0, 0, 16'h0000, 0, 0);
    add(0, 0, 16'h0700, 1, 1, 16'h0100, 1, 16'h0100, 0, 0, 0, 16'h0000, 0, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0100, 1, 0);
    add(1, 0, 16'h0000, 0, 1, 16'h0100, 1, 16'h0000, 0, 0, 0, 16'h0100, 1, 0);

    // reset state
    rst = 1'b1;
    idle_inputs();
    #3;
    check("reset psum_out", pe_psum_out, 16'h0000);
    check("reset psum_valid_out", {15'd0, pe_psum_valid_out}, 16'h0000);
    check("reset input_out", pe_input_out, 16'h0000);
    check("reset sat_out", {15'd0, pe_sat_out}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      step();
      check($sformatf("row%0d psum_out", i), pe_psum_out, vecs[i].e_ps);
      check($sformatf("row%0d psum_valid_out", i), {15'd0, pe_psum_valid_out}, {15'd0, vecs[i].e_pv});
      check($sformatf("row%0d sat_out", i), {15'd0, pe_sat_out}, {15'd0, vecs[i].e_sat});
    end

    // east/south forwards
    @(negedge clk);
    idle_inputs();
    pe_weight_in = 16'h0ABC; pe_accept_w_in = 1'b1;
    pe_input_in  = 16'h0055; pe_valid_in    = 1'b1;
    pe_switch_in = 1'b1;     pe_drain_in    = 1'b1;
    step();
    check("fwd weight_out", pe_weight_out, 16'h0ABC);
    check("fwd accept_w_out", {15'd0, pe_accept_w_out}, 16'h0001);
    check("fwd input_out", pe_input_out, 16'h0055);
    check("fwd valid_out", {15'd0, pe_valid_out}, 16'h0001);
    check("fwd switch_out", {15'd0, pe_switch_out}, 16'h0001);
    check("fwd drain_out", {15'd0, pe_drain_out}, 16'h0001);
    check("fwd psum_out", pe_psum_out, 16'h0055);

    @(negedge clk);
    idle_inputs();
    pe_weight_in = 16'h0BCD; pe_input_in = 16'h0066;
    step();
    check("hold weight_out", pe_weight_out, 16'h0000);
    check("hold accept_w_out", {15'd0, pe_accept_w_out}, 16'h0000);
    check("hold input_out", pe_input_out, 16'h0055);
    check("hold valid_out", {15'd0, pe_valid_out}, 16'h0000);
    check("hold switch_out", {15'd0, pe_switch_out}, 16'h0000);
    check("hold drain_out", {15'd0, pe_drain_out}, 16'h0000);

    @(negedge clk);
    idle_inputs();
    pe_enabled = 1'b0; pe_input_in = 16'h0077; pe_valid_in = 1'b1;
    step();
    check("disabled input_out", pe_input_out, 16'h0000);
    check("disabled valid_out", {15'd0, pe_valid_out}, 16'h0000);

    // asynchronous reset mid-accumulate
    @(negedge clk);
    idle_inputs();
    pe_mode_in = 1'b1; pe_input_in = 16'h0100; pe_valid_in = 1'b1;
    pe_psum_in = 16'h1111; pe_psum_valid_in = 1'b1;
    step();
    check("pre-reset psum_out", pe_psum_out, 16'h1111);
    check("pre-reset psum_valid_out", {15'd0, pe_psum_valid_out}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset psum_out", pe_psum_out, 16'h0000);
    check("async reset psum_valid_out", {15'd0, pe_psum_valid_out}, 16'h0000);
    check("async reset input_out", pe_input_out, 16'h0000);
    check("async reset valid_out", {15'd0, pe_valid_out}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    pe_mode_in = 1'b1; pe_drain_in = 1'b1;
    step();
    check("drain after reset psum_out", pe_psum_out, 16'h0000);
    check("drain after reset psum_valid_out", {15'd0, pe_psum_valid_out}, 16'h0001);

    // banks cleared by reset: switch must not promote the pre-reset weight
    @(negedge clk);
    idle_inputs();
    pe_switch_in = 1'b1; pe_input_in = 16'h0100; pe_valid_in = 1'b1;
    step();
    check("post-reset switch psum_out", pe_psum_out, 16'h0000);
    check("post-reset switch psum_valid_out", {15'd0, pe_psum_valid_out}, 16'h0001);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_db.md
# pe_mac_db

Parametrised second-generation processing element for the systolic array. It is a signed fixed-point MAC cell with a configurable data width and fraction width, plus round-to-nearest and saturating arithmetic. It has a flagged double-buffered weight register with same-cycle switch bypass, and a selectable output-stationary accumulate/drain mode beside the weight-stationary mode. It is tiled in the same N×N grid: psum and weights flow north→south, while inputs and control flow west→east.

## Interface
- DATA_WIDTH, 16, width of input/weight/psum words (signed, ≥4)
- FRAC_BITS, 8, fractional bits of the fixed-point format (1..DATA_WIDTH-2)
- ACC_WIDTH, 32, width of the OS-mode accumulator (≥ DATA_WIDTH+4)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pe_enabled  in  1  gates the cell; low = outputs cleared, state held
- pe_mode_in  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS)
- pe_psum_in  in  DATA_WIDTH  north partial sum
- pe_psum_valid_in  in  1  north psum valid (consumed in OS pass-through only)
- pe_weight_in  in  DATA_WIDTH  north weight
- pe_accept_w_in  in  1  load pe_weight_in into the inactive bank
- pe_input_in  in  DATA_WIDTH  west activation
- pe_valid_in  in  1  activation valid
- pe_switch_in  in  1  promote the inactive weight to active
- pe_drain_in  in  1  OS: emit the accumulator south and clear it
- pe_sat_clr  in  1  clear the sticky saturation flag
- pe_psum_out / pe_psum_valid_out  out  DATA_WIDTH / 1  south psum and valid
- pe_weight_out / pe_accept_w_out  out  DATA_WIDTH / 1  south weight forward
- pe_input_out / pe_valid_out / pe_switch_out / pe_drain_out  out  DATA_WIDTH/1/1/1  east forwards
- pe_sat_out  out  1  sticky saturation flag

## Operation
- Weight banks: `w_inactive`, `w_full`, `w_active`.
  - accept_w: `w_inactive`←weight, `w_full`←1.
  - switch with `w_full`=1: `w_active`←`w_inactive`, `w_full`←0.
  - switch with `w_full`=0: `w_active` unchanged (no-op).
- Effective weight: `w_eff` = (switch && `w_full`) ? `w_inactive` : `w_active`. A MAC in the switch cycle therefore uses the new weight.
- accept_w and switch in the same cycle: the old `w_inactive` is promoted, the new weight is loaded, and `w_full` stays 1.
- Product: full 2·DATA_WIDTH signed product, add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, giving `prod`.
- WS mode, valid_in=1: psum_out ← sat_W(sat_W(`prod`) + psum_in), psum_valid_out←1.
- WS mode, valid_in=0: psum_out←0, psum_valid_out←0.
- WS mode: psum_valid_in is ignored, and `acc` is held at 0.
- OS mode, valid_in=1: `acc` ← sat_ACC(`acc` + sext(`prod`)).
- OS mode, drain_in=1:
  - psum_out ← sat_W(`acc` before the update), psum_valid_out←1.
  - `acc` ← (valid_in ? sext(`prod`) : 0). A new tile starts in the same cycle.
- OS mode, no drain: psum_out/psum_valid_out ← psum_in/psum_valid_in (south pass-through). If drain and psum_valid_in collide, drain wins, the north word is dropped, and sat_out is set.
- Saturation: every clamp event sets `sat`. A set in the same cycle as sat_clr wins, so no event is lost.
- pe_enabled=0: all *_out data and valids go to 0 on the next edge. `w_*`, `acc` and `sat` are held, and inputs are ignored.

## Timing
- Every output is registered, with 1-cycle latency from the corresponding input. There is no backpressure.
- Forwards: input/valid/switch/drain go east, and weight/accept_w go south, each delayed 1 cycle.
- input_out updates only when valid_in=1 and otherwise holds. weight_out is 0 when accept_w_in=0.
- Reset: every output, `w_*`, `acc`, `w_full` and `sat` go to 0 immediately and asynchronously.
- Reset mid-drain or mid-accumulate discards the data. The first edge after deassertion behaves as from idle.
- mode_in is sampled every cycle. WS→OS starts with `acc`=0. OS→WS discards `acc`.

## Structure
- Shared package `pe_pkg` holds:
  - `pe_mode_e` (PE_WS, PE_OS).
  - Default-width localparams.
  - Saturating-clamp helper function, parametrised via a width argument.
- Sub-module `pe_fxp_mul_rnd` is combinational: it performs multiply, round and shift, and reports its saturation. It is instantiated once, and the adder/accumulator stay in the parent.

## Test plan
(DATA_WIDTH=16, FRAC_BITS=8)
- WS basic: load w=0x0200, switch, input 0x0180, psum_in 0x0100 → next cycle psum_out=0x0400, psum_valid_out=1, sat_out=0.
- Switch bypass: w_active=0x0100, w_inactive=0x0300 (full); switch+valid with input 0x0100 in the same cycle → psum_out=0x0300. A second switch with full=0 leaves the weight unchanged.
- Saturation: w=0x7F00, input 0x7F00, psum 0 → psum_out=0x7FFF, sat_out=1. Then sat_clr → sat_out=0. Input 0x8000 × w 0x7F00 → psum_out=0x8000.
- OS accumulate: w=0x0100, inputs 0x0100, 0x0200, 0x0300 on consecutive cycles, then drain with valid and input 0x0100 → psum_out=0x0600; a second drain → 0x0100.
- OS pass-through/collision: psum_valid_in with 0x1234, no drain → 0x1234 south after 1 cycle. Drain in the same cycle → acc value emitted, sat_out=1.
- Reset/enable: assert rst mid-accumulate → outputs 0 asynchronously and drain yields 0. Hold pe_enabled=0 for 3 cycles → outputs 0 and `w_active` retained on re-enable.
